// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM stage and data memory: FIFO of stores drained
// one per cycle, youngest-match load forwarding, and a fence drain handshake.
module store_buffer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic                     req_read,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic [DATA_W-1:0]        load_data,
    output logic                     stall,
    input  logic                     fence,
    output logic                     fence_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     state_memory,
    output logic                     mem_read_flag,
    output logic                     mem_write_flag,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WA_W  = ADDR_W - 2;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FENCE = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WA_W-1:0]    wa_q [DEPTH];
    logic [DATA_W-1:0]  wd_q [DEPTH];

    logic               is_run;
    logic               req_ld;
    logic               hit;
    logic [DATA_W-1:0]  hit_data;
    logic               ld_miss;
    logic               drain;
    logic               enq;

    // Request decode, forwarding search and memory-port arbitration
    always_comb begin
        is_run   = (state_q == S_RUN);
        req_ld   = !rst && is_run && req_valid && req_read;
        hit      = 1'b0;
        hit_data = '0;
        // Walk oldest to youngest so the last match wins
        for (int k = 0; k < int'(DEPTH); k++) begin
            if ((CNT_W'(k) < count_q) &&
                (wa_q[head_q + PTR_W'(k)] == req_addr[ADDR_W-1:2])) begin
                hit      = 1'b1;
                hit_data = wd_q[head_q + PTR_W'(k)];
            end
        end
        ld_miss = req_ld && !hit;
        drain   = !rst && (count_q != '0) && !ld_miss;
        enq     = !rst && is_run && req_valid && req_write;

        load_data      = req_ld ? (hit ? hit_data : mem_rdata) : '0;
        mem_read_flag  = ld_miss;
        mem_write_flag = drain;
        state_memory   = ld_miss | drain;
        mem_addr       = '0;
        mem_wdata      = '0;
        if (ld_miss) begin
            mem_addr = req_addr;
        end else if (drain) begin
            mem_addr  = {wa_q[head_q], 2'b00};
            mem_wdata = wd_q[head_q];
        end

        count_d = count_q + CNT_W'(enq) - CNT_W'(drain);
        head_d  = head_q + PTR_W'(drain);
        tail_d  = tail_q + PTR_W'(enq);
        count   = rst ? '0 : count_q;
    end

    // Fence sequencing; done pulses in the cycle the buffer reads empty
    always_comb begin
        state_d    = state_q;
        fence_done = 1'b0;
        stall      = 1'b0;
        if (!rst) begin
            case (state_q)
                S_RUN: begin
                    if (fence) begin
                        if (count_q == '0) fence_done = 1'b1;
                        else               state_d    = S_FENCE;
                    end
                end
                S_FENCE: begin
                    if (count_q == '0) begin
                        fence_done = 1'b1;
                        state_d    = S_RUN;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq) begin
                wa_q[tail_q] <= req_addr[ADDR_W-1:2];
                wd_q[tail_q] <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_read;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] load_data;
    logic        stall, fence, fence_done;
    logic [2:0]  count;
    logic        state_memory, mem_read_flag, mem_write_flag;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    store_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_read(req_read),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .load_data(load_data), .stall(stall),
        .fence(fence), .fence_done(fence_done), .count(count),
        .state_memory(state_memory),
        .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Reference model: the buffer is an ordered list of pending stores
    typedef struct {
        logic [29:0] wa;
        logic [31:0] d;
    } ent_t;
    ent_t sb[$];
    bit   m_fence;

    logic [31:0] e_load, e_addr, e_wd;
    logic        e_rf, e_wf, e_done, e_stall, e_enq, e_next_fence;
    int          e_cnt;

    task automatic drive(input logic v, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic f, input logic [31:0] rd);
        req_valid = v; req_write = w; req_read = r;
        req_addr = a; req_wdata = d; fence = f; mem_rdata = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_eval();
        bit run, ld, hit, miss;
        logic [31:0] hd;
        e_load = 0; e_addr = 0; e_wd = 0; e_rf = 0; e_wf = 0;
        e_done = 0; e_stall = 0; e_enq = 0; e_next_fence = 0; e_cnt = 0;
        if (rst) return;
        run = !m_fence;
        ld  = run && req_valid && req_read;
        hit = 0; hd = 0;
        foreach (sb[i]) if (sb[i].wa == req_addr[31:2]) begin hit = 1; hd = sb[i].d; end
        miss = ld && !hit;
        e_wf = (sb.size() > 0) && !miss;
        e_rf = miss;
        e_load = ld ? (hit ? hd : mem_rdata) : 32'h0;
        if (miss)      e_addr = req_addr;
        else if (e_wf) begin e_addr = {sb[0].wa, 2'b00}; e_wd = sb[0].d; end
        e_cnt   = sb.size();
        e_done  = (sb.size() == 0) && (m_fence || fence);
        e_stall = m_fence && (sb.size() > 0);
        e_enq   = run && req_valid && req_write;
        e_next_fence = (m_fence || fence) && (sb.size() != 0);
    endtask

    task automatic model_commit();
        if (rst) begin
            sb.delete();
            m_fence = 0;
        end else begin
            ent_t e;
            if (e_wf) void'(sb.pop_front());
            if (e_enq) begin e.wa = req_addr[31:2]; e.d = req_wdata; sb.push_back(e); end
            m_fence = e_next_fence;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 0, 32'hDEAD_BEEF);
        tick(); #2;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (fence_done !== 1'b0) begin bad++; $display("FAIL reset_fence_done got=%b exp=0", fence_done); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if ({mem_read_flag, mem_write_flag, state_memory} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b exp=000", {mem_read_flag, mem_write_flag, state_memory}); end
        total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || load_data !== 32'h0) begin
            bad++; $display("FAIL reset_buses got=%h/%h/%h exp=0", mem_addr, mem_wdata, load_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store_drain();
        drive(1, 1, 0, 32'h10, 32'h11, 0, 32'h0);
        #2;
        total++; if (mem_write_flag !== 1'b0) begin bad++; $display("FAIL sd_early_write got=%b exp=0", mem_write_flag); end
        tick();
        drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        #2;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL sd_count1 got=%0d exp=1", count); end
        total++; if (mem_write_flag !== 1'b1 || state_memory !== 1'b1) begin
            bad++; $display("FAIL sd_write got=%b%b exp=11", mem_write_flag, state_memory); end
        total++; if (mem_addr !== 32'h10 || mem_wdata !== 32'h11) begin
            bad++; $display("FAIL sd_payload got=%h/%h exp=10/11", mem_addr, mem_wdata); end
        tick(); #2;
        total++; if (count !== 3'd0 || mem_write_flag !== 1'b0) begin
            bad++; $display("FAIL sd_empty got=%0d/%b exp=0/0", count, mem_write_flag); end
    endtask

    task automatic test_forward();
        drive(1, 1, 0, 32'h20, 32'hA, 0, 32'h0); tick();
        drive(1, 1, 0, 32'h20, 32'hB, 0, 32'h0); tick();
        drive(1, 0, 1, 32'h20, 32'h0, 0, 32'h77);
        #2;
        total++; if (load_data !== 32'hB) begin bad++; $display("FAIL fw_data got=%h exp=b", load_data); end
        total++; if (mem_read_flag !== 1'b0 || mem_write_flag !== 1'b1) begin
            bad++; $display("FAIL fw_port got=%b%b exp=01", mem_read_flag, mem_write_flag); end
        tick();
        drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        #2;
        total++; if (count !== 3'd0 || load_data !== 32'h0) begin
            bad++; $display("FAIL fw_after got=%0d/%h exp=0/0", count, load_data); end
        tick();
    endtask

    task automatic test_load_miss();
        drive(1, 1, 0, 32'h50, 32'h5, 0, 32'h0); tick();
        drive(1, 0, 1, 32'h60, 32'h0, 0, 32'h55);
        #2;
        total++; if (load_data !== 32'h55) begin bad++; $display("FAIL lm_data got=%h exp=55", load_data); end
        total++; if (mem_read_flag !== 1'b1 || mem_write_flag !== 1'b0 || mem_addr !== 32'h60) begin
            bad++; $display("FAIL lm_port got=%b%b/%h exp=10/60", mem_read_flag, mem_write_flag, mem_addr); end
        tick();
        drive(1, 0, 1, 32'h52, 32'h0, 0, 32'h99);
        #2;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL lm_held got=%0d exp=1", count); end
        total++; if (load_data !== 32'h5 || mem_read_flag !== 1'b0) begin
            bad++; $display("FAIL lm_wordhit got=%h/%b exp=5/0", load_data, mem_read_flag); end
        tick();
        drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0); tick();
    endtask

    task automatic test_fence();
        drive(1, 1, 0, 32'h30, 32'h33, 0, 32'h0); tick();
        drive(1, 1, 0, 32'h34, 32'h44, 1, 32'h0);
        #2;
        total++; if (stall !== 1'b0 || fence_done !== 1'b0 || mem_addr !== 32'h30) begin
            bad++; $display("FAIL fe_req got=%b%b/%h exp=00/30", stall, fence_done, mem_addr); end
        tick();
        drive(1, 0, 1, 32'h80, 32'h0, 1, 32'h99);
        #2;
        total++; if (stall !== 1'b1 || fence_done !== 1'b0) begin
            bad++; $display("FAIL fe_stall got=%b%b exp=10", stall, fence_done); end
        total++; if (mem_read_flag !== 1'b0 || mem_write_flag !== 1'b1 || mem_addr !== 32'h34 || mem_wdata !== 32'h44) begin
            bad++; $display("FAIL fe_drain got=%b%b/%h/%h exp=01/34/44", mem_read_flag, mem_write_flag, mem_addr, mem_wdata); end
        tick();
        drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        #2;
        total++; if (fence_done !== 1'b1 || stall !== 1'b0 || count !== 3'd0 || mem_write_flag !== 1'b0) begin
            bad++; $display("FAIL fe_done got=%b%b/%0d/%b exp=10/0/0", fence_done, stall, count, mem_write_flag); end
        tick(); #2;
        total++; if (fence_done !== 1'b0) begin bad++; $display("FAIL fe_single got=%b exp=0", fence_done); end
        drive(0, 0, 0, 32'h0, 32'h0, 1, 32'h0);
        #2;
        total++; if (fence_done !== 1'b1 || stall !== 1'b0) begin
            bad++; $display("FAIL fe_empty got=%b%b exp=10", fence_done, stall); end
        tick(); #2;
        total++; if (fence_done !== 1'b1) begin bad++; $display("FAIL fe_repeat got=%b exp=1", fence_done); end
        drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0); tick();
    endtask

    task automatic test_reset_mid_fence();
        drive(1, 1, 0, 32'h70, 32'h7, 0, 32'h0); tick();
        drive(1, 1, 0, 32'h74, 32'h8, 1, 32'h0); tick();
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 1, 32'h0);
        #2;
        total++; if (mem_write_flag !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL rmf_in_reset got=%b%b exp=00", mem_write_flag, stall); end
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        #2;
        total++; if (count !== 3'd0 || stall !== 1'b0 || mem_write_flag !== 1'b0 || fence_done !== 1'b0) begin
            bad++; $display("FAIL rmf_after got=%0d/%b%b%b exp=0/000", count, stall, mem_write_flag, fence_done); end
        tick();
    endtask

    task automatic test_random();
        bit fence_req = 0;
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        model_eval(); @(posedge clk); model_commit(); #1;
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int op;
            logic [31:0] a;
            rst = ($urandom_range(0, 199) == 0);
            if (rst) fence_req = 0;
            else if (!fence_req && $urandom_range(0, 39) == 0) fence_req = 1;
            op = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? (32'h200 + 32'($urandom_range(0, 63)))
                                            : (32'h100 + 32'($urandom_range(0, 15)));
            drive(op < 7, op < 4, (op >= 4) && (op < 7), a, $urandom(), fence_req, $urandom());
            model_eval();
            #2;
            total++; if (load_data !== e_load) begin bad++; $display("FAIL rnd_load cyc=%0d got=%h exp=%h", cyc, load_data, e_load); end
            total++; if (mem_read_flag !== e_rf) begin bad++; $display("FAIL rnd_rflag cyc=%0d got=%b exp=%b", cyc, mem_read_flag, e_rf); end
            total++; if (mem_write_flag !== e_wf) begin bad++; $display("FAIL rnd_wflag cyc=%0d got=%b exp=%b", cyc, mem_write_flag, e_wf); end
            total++; if (state_memory !== (e_rf | e_wf)) begin bad++; $display("FAIL rnd_smem cyc=%0d got=%b exp=%b", cyc, state_memory, e_rf | e_wf); end
            total++; if (mem_addr !== e_addr) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, e_addr); end
            total++; if (mem_wdata !== e_wd) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, e_wd); end
            total++; if (int'(count) !== e_cnt) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count, e_cnt); end
            total++; if (stall !== e_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, stall, e_stall); end
            total++; if (fence_done !== e_done) begin bad++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", cyc, fence_done, e_done); end
            if (e_done) fence_req = 0;
            @(posedge clk);
            model_commit();
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        #1;
        test_reset();
        test_store_drain();
        test_forward();
        test_load_miss();
        test_fence();
        test_reset_mid_fence();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
